// File: rtl/simd_pipe_reg.sv
// Elastic, lane-masked pipeline register between SIMD stages: optional two-entry skid buffer,
// synchronous flush and a wrapping transfer counter for performance debug.
module simd_pipe_reg #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [LANES-1:0]        in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        xfer_count
);
    localparam int DW = LANES * LANE_W;

    // Handshake: a beat moves on a rising edge when valid and ready are both high on that side;
    // valid never depends on ready, and out_data/out_mask hold while out_valid=1 and out_ready=0.

    logic             r_main_v;
    logic             r_skid_v;
    logic [DW-1:0]    r_main_d;
    logic [DW-1:0]    r_skid_d;
    logic [LANES-1:0] r_main_m;
    logic [LANES-1:0] r_skid_m;
    logic [1:0]       r_occ;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [DW-1:0]    w_in_gated;
    logic             w_main_v_nxt;
    logic             w_skid_v_nxt;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    if (SKID != 0) begin : g_skid
        assign in_ready = ~r_skid_v;
    end else begin : g_noskid
        assign in_ready = ~r_main_v | out_ready;
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_main_v & out_ready;

    // Inactive lanes are stored as zero so downstream never sees stale lane contents.
    always_comb begin
        w_in_gated = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_mask[i]) begin
                w_in_gated[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        w_main_v_nxt     = r_main_v;
        w_skid_v_nxt     = r_skid_v;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (SKID != 0) begin
            if (r_skid_v) begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_skid_v_nxt     = 1'b0;
                end
            end else if (r_main_v) begin
                if (w_out_fire) begin
                    if (w_in_fire) w_load_main_in = 1'b1;
                    else           w_main_v_nxt   = 1'b0;
                end else if (w_in_fire) begin
                    w_load_skid  = 1'b1;
                    w_skid_v_nxt = 1'b1;
                end
            end else if (w_in_fire) begin
                w_load_main_in = 1'b1;
                w_main_v_nxt   = 1'b1;
            end
        end else begin
            if (w_in_fire) begin
                w_load_main_in = 1'b1;
                w_main_v_nxt   = 1'b1;
            end else if (w_out_fire) begin
                w_main_v_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
            r_main_m <= '0;
            r_skid_m <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_skid_v <= w_skid_v_nxt;
            r_occ    <= {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};
            if (w_load_main_in) begin
                r_main_d <= w_in_gated;
                r_main_m <= in_mask;
            end else if (w_load_main_skid) begin
                r_main_d <= r_skid_d;
                r_main_m <= r_skid_m;
            end
            if (w_load_skid) begin
                r_skid_d <= w_in_gated;
                r_skid_m <= in_mask;
            end
            // A transfer leaving in a flush cycle still completed, so flush does not gate this.
            if (w_out_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_main_v;
    assign out_data   = r_main_d;
    assign out_mask   = r_main_m;
    assign occupancy  = r_occ;
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_simd_pipe_reg.sv
// Scoreboard bench for simd_pipe_reg: a skid instance (CNT_W=16) and a single-entry
// instance (CNT_W=4), each checked against a FIFO-queue reference model.
module tb_simd_pipe_reg;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int DW     = LANES * LANE_W;
    localparam int EW     = DW + LANES;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [DW-1:0]    in_data1, out_data1;
    logic [LANES-1:0] in_mask1, out_mask1;
    logic [1:0]       occupancy1;
    logic [15:0]      xfer_count1;

    logic             flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [DW-1:0]    in_data0, out_data0;
    logic [LANES-1:0] in_mask0, out_mask0;
    logic [1:0]       occupancy0;
    logic [3:0]       xfer_count0;

    simd_pipe_reg #(.LANES(LANES), .LANE_W(LANE_W), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mask(in_mask1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_mask(out_mask1),
        .occupancy(occupancy1), .xfer_count(xfer_count1)
    );

    simd_pipe_reg #(.LANES(LANES), .LANE_W(LANE_W), .SKID(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_mask(in_mask0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_mask(out_mask0),
        .occupancy(occupancy0), .xfer_count(xfer_count0)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q0[$];
    int cnt1 = 0;
    int cnt0 = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each active lane passes through, each inactive lane reads as zero.
    function automatic logic [DW-1:0] lane_gate(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor for the skid instance: the model is a FIFO of at most two entries.
    always @(negedge clk) begin
        if (reset) begin
            exp_q1.delete();
            cnt1 = 0;
        end else begin
            logic ready_m;
            ready_m = (exp_q1.size() < 2);
            chk("occupancy1", occupancy1, exp_q1.size());
            chk("out_valid1", out_valid1, exp_q1.size() != 0);
            chk("in_ready1", in_ready1, ready_m);
            chk("xfer_count1", xfer_count1, cnt1 % 65536);
            if (out_valid1 && exp_q1.size() != 0) chk("data1", {out_mask1, out_data1}, exp_q1[0]);
            if (exp_q1.size() != 0 && out_ready1) begin
                void'(exp_q1.pop_front());
                cnt1++;
            end
            if (flush1) exp_q1.delete();
            else if (in_valid1 && ready_m) exp_q1.push_back({in_mask1, lane_gate(in_data1, in_mask1)});
        end
    end

    // Monitor for the single-entry instance: at most one entry, replaceable while draining.
    always @(negedge clk) begin
        if (reset) begin
            exp_q0.delete();
            cnt0 = 0;
        end else begin
            logic ready_m;
            ready_m = (exp_q0.size() == 0) || out_ready0;
            chk("occupancy0", occupancy0, exp_q0.size());
            chk("out_valid0", out_valid0, exp_q0.size() != 0);
            chk("in_ready0", in_ready0, ready_m);
            chk("xfer_count0", xfer_count0, cnt0 % 16);
            if (out_valid0 && exp_q0.size() != 0) chk("data0", {out_mask0, out_data0}, exp_q0[0]);
            if (exp_q0.size() != 0 && out_ready0) begin
                void'(exp_q0.pop_front());
                cnt0++;
            end
            if (flush0) exp_q0.delete();
            else if (in_valid0 && ready_m) exp_q0.push_back({in_mask0, lane_gate(in_data0, in_mask0)});
        end
    end

    // Called just after a rising edge; returns just after the edge on which the beat was taken.
    task automatic send1(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        int n;
        n = 0;
        in_valid1 = 1'b1;
        in_data1  = d;
        in_mask1  = m;
        @(negedge clk);
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send1_timeout", n >= 200, 1'b0);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain1();
        int n;
        n = 0;
        out_ready1 = 1'b1;
        while (occupancy1 !== 2'd0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain1_timeout", n >= 200, 1'b0);
    endtask

    task automatic drain0();
        int n;
        n = 0;
        out_ready0 = 1'b1;
        while (occupancy0 !== 2'd0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain0_timeout", n >= 200, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a_d, b_d, lane_d;
        reset = 1'b1;
        flush1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = '0; in_mask1 = '0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0; in_mask0 = '0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid1, 1'b0);
        chk("rst_out_data", out_data1, '0);
        chk("rst_out_mask", out_mask1, '0);
        chk("rst_occupancy", occupancy1, 2'd0);
        chk("rst_xfer", xfer_count1, 16'd0);
        chk("rst_in_ready", in_ready1, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Asynchronous reset while an entry is held.
        out_ready1 = 1'b0;
        send1({96'h0, 32'hDEADBEEF}, 4'hF);
        chk("held_deadbeef", out_data1, {96'h0, 32'hDEADBEEF});
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid1, 1'b0);
        chk("async_out_data", out_data1, '0);
        chk("async_occupancy", occupancy1, 2'd0);
        chk("async_in_ready", in_ready1, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming: 8 back-to-back beats with lane0 = 1..8.
        out_ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            lane_d = rand_data();
            lane_d[31:0] = 32'(i);
            send1(lane_d, 4'hF);
        end
        drain1();
        chk("stream_xfer", xfer_count1, 16'd8);

        // Backpressure: A and B held, A stable at the output.
        out_ready1 = 1'b0;
        a_d = rand_data();
        b_d = rand_data();
        send1(a_d, 4'hF);
        send1(b_d, 4'hF);
        chk("bp_occupancy", occupancy1, 2'd2);
        chk("bp_in_ready", in_ready1, 1'b0);
        chk("bp_data_a", out_data1, a_d);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_data_a_hold", out_data1, a_d);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after_a", in_ready1, 1'b1);
        chk("bp_data_b", out_data1, b_d);
        drain1();

        // Lane mask 0101.
        out_ready1 = 1'b0;
        send1({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b0101);
        chk("mask_data", out_data1, {32'h0, 32'h33333333, 32'h0, 32'h11111111});
        chk("mask_mask", out_mask1, 4'b0101);
        drain1();
        chk("mask_xfer", xfer_count1, 16'd11);

        // Flush with two entries held and a colliding input.
        out_ready1 = 1'b0;
        send1(rand_data(), 4'hF);
        send1(rand_data(), 4'hF);
        flush1 = 1'b1;
        in_valid1 = 1'b1;
        in_data1 = rand_data();
        in_mask1 = 4'hF;
        @(posedge clk);
        #1;
        flush1 = 1'b0;
        in_valid1 = 1'b0;
        chk("flush2_occupancy", occupancy1, 2'd0);
        chk("flush2_out_valid", out_valid1, 1'b0);
        chk("flush2_in_ready", in_ready1, 1'b1);
        chk("flush2_xfer", xfer_count1, 16'd11);

        // Flush with one entry held: in_ready is high, input must still be dropped.
        send1(rand_data(), 4'hF);
        flush1 = 1'b1;
        in_valid1 = 1'b1;
        in_data1 = rand_data();
        @(posedge clk);
        #1;
        flush1 = 1'b0;
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush1_out_valid", out_valid1, 1'b0);
        chk("flush1_xfer", xfer_count1, 16'd11);

        // Random traffic with occasional flush.
        for (int c = 0; c < 1500; c++) begin
            in_valid1  = ($urandom_range(0, 9) < 7);
            in_data1   = rand_data();
            in_mask1   = 4'($urandom_range(0, 15));
            out_ready1 = ($urandom_range(0, 9) < 6);
            flush1     = ($urandom_range(0, 99) < 2);
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;
        flush1 = 1'b0;
        drain1();

        // Single-entry instance: 17 full-rate transfers wrap the 4-bit counter to 1.
        in_valid0 = 1'b1;
        out_ready0 = 1'b1;
        in_mask0 = 4'hF;
        for (int i = 1; i <= 17; i++) begin
            lane_d = rand_data();
            lane_d[31:0] = 32'(i);
            in_data0 = lane_d;
            chk("wrap_no_bubble_ready", in_ready0, 1'b1);
            if (i >= 2) chk("wrap_no_bubble_valid", out_valid0, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid0 = 1'b0;
        drain0();
        chk("wrap_xfer", xfer_count0, 4'd1);

        for (int c = 0; c < 1000; c++) begin
            in_valid0  = ($urandom_range(0, 9) < 7);
            in_data0   = rand_data();
            in_mask0   = 4'($urandom_range(0, 15));
            out_ready0 = ($urandom_range(0, 9) < 6);
            flush0     = ($urandom_range(0, 99) < 2);
            @(posedge clk);
            #1;
        end
        in_valid0 = 1'b0;
        flush0 = 1'b0;
        drain0();
        repeat (2) @(posedge clk);
        #1;
        chk("end_q1_empty", exp_q1.size(), 0);
        chk("end_q0_empty", exp_q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
